hilo_mac: RTL

HILO_MAC -- requirements
Module: hilo_mac

---
 rtl/hilo_mac.sv | 68 ++++++
 1 files changed

// File: rtl/hilo_mac.sv
// hilo_mac: HI/LO multiply-accumulate unit with fixed-latency commit, flush and direct writes
module hilo_mac #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic [WIDTH-1:0] hi_wdata_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] lo_wdata_i,
  input  logic             rd_sel_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] op_r;
  logic [WIDTH-1:0] a_r, b_r, hi, lo;
  logic [2*WIDTH-1:0] ea, eb, p, acc, r;
  logic accept, commit;
  assign busy_o = state == BUSY;
  assign accept = op_valid_i & ~busy_o & ~flush_i & (op_i[2:1] != 2'b11);
  assign commit = busy_o & ~flush_i & (cnt == CW'(1));
  assign rd_data_o = rd_sel_i ? ((hi_we_i & ~busy_o) ? hi_wdata_i : hi)
                              : ((lo_we_i & ~busy_o) ? lo_wdata_i : lo);
  always_comb begin
    ea = op_r[0] ? {{WIDTH{1'b0}}, a_r} : {{WIDTH{a_r[WIDTH-1]}}, a_r};
    eb = op_r[0] ? {{WIDTH{1'b0}}, b_r} : {{WIDTH{b_r[WIDTH-1]}}, b_r};
    p = ea * eb;
    acc = {hi, lo};
    r = op_r[2] ? acc - p : op_r[1] ? acc + p : p;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= commit;
      if (busy_o) begin
        cnt <= flush_i ? '0 : cnt - CW'(1);
        if (flush_i || cnt == CW'(1)) state <= IDLE;
        if (commit) {hi, lo} <= r;
      end else begin
        if (hi_we_i) hi <= hi_wdata_i;
        if (lo_we_i) lo <= lo_wdata_i;
        if (accept) begin
          op_r <= op_i;
          a_r <= op_a_i;
          b_r <= op_b_i;
          cnt <= CW'(MUL_LAT);
          state <= BUSY;
        end
      end
    end
  end
endmodule
